audio_tone_gen: RTL and testbench

//  Parametrised beep/tone source for the audio codec path; drives one signed sample per codec sample_req.

---
 rtl/audio_tone_gen.sv | 134 +++++++++++++
 tb/tb_audio_tone_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: NCO tone source (sine table or square) with volume scaling and codec loop-back.
// Define AUDIO_TONE_ENVELOPE_EN for the attack/release envelope FSM; otherwise the gain steps instantly.
module audio_tone_gen #(
   parameter int SAMPLE_W    = 16,
   parameter int ADDR_W      = 7,
   parameter int PHASE_W     = 16,
   parameter int VOL_W       = 8,
   parameter int ATTACK_STEP = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       sample_req,
   input  logic                       sample_end,
   input  logic signed [SAMPLE_W-1:0] audio_input,
   output logic signed [SAMPLE_W-1:0] audio_output,
   input  logic [1:0]                 mode,
   input  logic                       tone_en,
   input  logic [PHASE_W-1:0]         freq_step,
   input  logic [VOL_W-1:0]           volume,
   output logic                       busy
);

   localparam int  DEPTH = 2 ** ADDR_W;
   localparam int  PW    = SAMPLE_W + VOL_W + 1;
   localparam real PI    = 3.14159265358979323846;
   localparam real AMP   = real'(2 ** (SAMPLE_W - 1) - 1);
   localparam logic signed [SAMPLE_W-1:0] FS = SAMPLE_W'(2 ** (SAMPLE_W - 1) - 1);

   logic [PHASE_W-1:0]         phase, phase_nxt;
   logic [VOL_W-1:0]           env, env_nxt;
   logic signed [SAMPLE_W-1:0] last_sample, raw, out_nxt;
   logic signed [PW-1:0]       prod;
   logic                       busy_nxt;
   logic [ADDR_W-1:0]          rom_idx;
   logic signed [SAMPLE_W-1:0] rom [DEPTH];

   if (ADDR_W > PHASE_W || ATTACK_STEP < 1) begin : g_bad_params
      $error("audio_tone_gen: ADDR_W must not exceed PHASE_W and ATTACK_STEP must be >= 1");
   end

   // One full sine period, rounded to nearest, computed at elaboration (no external image).
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam real S = AMP * $sin(2.0 * PI * real'(i) / real'(DEPTH));
      localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
      assign rom[i] = SAMPLE_W'(V);
   end

   assign rom_idx = phase[PHASE_W-1 -: ADDR_W];

   always_comb begin
      raw = phase[PHASE_W-1] ? -FS : FS;
      if (mode == 2'b01) raw = rom[rom_idx];
      prod = PW'(raw) * PW'($signed({1'b0, env}));
      case (mode)
         2'b00:   out_nxt = '0;
         2'b11:   out_nxt = last_sample;
         default: out_nxt = SAMPLE_W'(prod >>> VOL_W);
      endcase
   end

`ifdef AUDIO_TONE_ENVELOPE_EN
   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
   state_t           state, state_nxt;
   logic [VOL_W:0]   env_up;
   logic [VOL_W-1:0] env_dn, env_sat_up;
   logic             env_at_top;

   assign env_up     = {1'b0, env} + (VOL_W + 1)'(ATTACK_STEP);
   assign env_at_top = env_up >= {1'b0, volume};
   assign env_sat_up = env_at_top ? volume : env_up[VOL_W-1:0];
   assign env_dn     = (env > VOL_W'(ATTACK_STEP)) ? env - VOL_W'(ATTACK_STEP) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        state <= IDLE;
      else if (sample_req) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      env_nxt   = env;
      case (state)
         IDLE: if (tone_en) begin
            env_nxt   = env_sat_up;
            state_nxt = ATTACK;
         end
         ATTACK: if (!tone_en) state_nxt = RELEASE;
            else begin
               // also catches volume lowered below env mid-attack
               env_nxt = env_sat_up;
               if (env_at_top) state_nxt = SUSTAIN;
            end
         SUSTAIN: if (tone_en) env_nxt = volume;
            else begin
               env_nxt   = env_dn;
               state_nxt = (env_dn == '0) ? IDLE : RELEASE;
            end
         RELEASE: if (tone_en) state_nxt = ATTACK;
            else begin
               env_nxt = env_dn;
               if (env_dn == '0) state_nxt = IDLE;
            end
         default: state_nxt = IDLE;
      endcase
      phase_nxt = (state == IDLE || state_nxt == IDLE) ? '0 : phase + freq_step;
      busy_nxt  = (state_nxt != IDLE) || (env_nxt != '0);
   end
`else
   always_comb begin
      env_nxt   = tone_en ? volume : '0;
      phase_nxt = tone_en ? phase + freq_step : '0;
      busy_nxt  = tone_en;
   end
`endif

   // last_sample is written with <=, so a coincident request still outputs the old sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         audio_output <= '0;
         busy         <= 1'b0;
         phase        <= '0;
         env          <= '0;
         last_sample  <= '0;
      end else begin
         if (sample_end) last_sample <= audio_input;
         if (sample_req) begin
            audio_output <= out_nxt;
            busy         <= busy_nxt;
            phase        <= phase_nxt;
            env          <= env_nxt;
         end
      end
   end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: vector table for loop-back/silence, scoreboard-checked tone sequences.
module tb_audio_tone_gen;

   logic        clk = 1'b0, reset_n = 1'b0, sample_req = 1'b0, sample_end = 1'b0, tone_en = 1'b0;
   logic        busy;
   logic [15:0] audio_input = '0, audio_output, freq_step = '0;
   logic [1:0]  mode = '0;
   logic [7:0]  volume = '0;

   always #5 clk = ~clk;

   audio_tone_gen dut (
      .clk(clk), .reset_n(reset_n), .sample_req(sample_req), .sample_end(sample_end),
      .audio_input(audio_input), .audio_output(audio_output), .mode(mode),
      .tone_en(tone_en), .freq_step(freq_step), .volume(volume), .busy(busy)
   );

   typedef struct {logic [15:0] out; logic busy;} exp_t;
   typedef struct {logic [1:0] mode; logic req; logic send; logic [15:0] ain; logic [15:0] out; logic busy;} vec_t;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0;
   int   sine_tab[128];

   localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;
   int          m_env = 0, m_phase = 0, m_state = S_IDLE;
   logic [15:0] m_last = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int scale(input int raw, input int e);
      return (raw * e) >>> 8;
   endfunction

   // Reference model of one sample request: expected output from pre-request state, then update.
   task automatic model_req(input logic [1:0] m, input bit te, input int step, input int vol);
      exp_t e;
      int   old_state;
      case (m)
         2'b00:   e.out = '0;
         2'b01:   e.out = 16'(scale(sine_tab[m_phase >> 9], m_env));
         2'b10:   e.out = 16'(scale((m_phase >= 32768) ? -32767 : 32767, m_env));
         default: e.out = m_last;
      endcase
`ifdef AUDIO_TONE_ENVELOPE_EN
      old_state = m_state;
      case (m_state)
         S_IDLE: if (te) begin m_env = (vol < 4) ? vol : 4; m_state = S_ATT; end
         S_ATT: begin
            if (!te) m_state = S_REL;
            else if (m_env + 4 >= vol) begin m_env = vol; m_state = S_SUS; end
            else m_env = m_env + 4;
         end
         S_SUS: begin
            if (te) m_env = vol;
            else begin
               m_env   = (m_env > 4) ? m_env - 4 : 0;
               m_state = (m_env == 0) ? S_IDLE : S_REL;
            end
         end
         default: begin
            if (te) m_state = S_ATT;
            else begin
               m_env = (m_env > 4) ? m_env - 4 : 0;
               if (m_env == 0) m_state = S_IDLE;
            end
         end
      endcase
      if (old_state == S_IDLE || m_state == S_IDLE) m_phase = 0;
      else m_phase = (m_phase + step) % 65536;
      e.busy = (m_state != S_IDLE) || (m_env != 0);
`else
      old_state = m_state;
      m_env   = te ? vol : 0;
      m_phase = te ? (m_phase + step) % 65536 : 0;
      e.busy  = te;
`endif
      sb.push_back(e);
   endtask

   task automatic do_req(input logic [1:0] m, input bit te, input logic [15:0] step,
                         input logic [7:0] vol, input string nm, output logic [15:0] got);
      exp_t e;
      mode = m; tone_en = te; freq_step = step; volume = vol; sample_req = 1'b1;
      model_req(m, te, int'(step), int'(vol));
      @(posedge clk); #1;
      sample_req = 1'b0;
      e   = sb.pop_front();
      got = audio_output;
      check({nm, " out"}, 32'(audio_output), 32'(e.out));
      check({nm, " busy"}, 32'(busy), 32'(e.busy));
      @(posedge clk); #1;
      check({nm, " hold"}, 32'(audio_output), 32'(e.out));
   endtask

   task automatic run_reqs(input logic [1:0] m, input bit te, input logic [15:0] step,
                           input logic [7:0] vol, input int n, input string nm);
      logic [15:0] g;
      for (int i = 0; i < n; i++) do_req(m, te, step, vol, $sformatf("%s[%0d]", nm, i), g);
   endtask

   initial begin
      vec_t        tv[10];
      logic [15:0] a, b;

      for (int i = 0; i < 128; i++) begin
         real s;
         s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / 128.0);
         sine_tab[i] = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
      end

      // reset held with random inputs, then quiet after release
      for (int i = 0; i < 6; i++) begin
         sample_req = 1'($urandom); sample_end = 1'($urandom); audio_input = 16'($urandom);
         mode = 2'($urandom); tone_en = 1'($urandom); freq_step = 16'($urandom); volume = 8'($urandom);
         @(posedge clk); #1;
         check("rst out", 32'(audio_output), 32'h0);
         check("rst busy", 32'(busy), 32'h0);
      end
      sample_req = 1'b0; sample_end = 1'b0; audio_input = '0; mode = '0;
      tone_en = 1'b0; freq_step = '0; volume = '0;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post-rst out", 32'(audio_output), 32'h0);
         check("post-rst busy", 32'(busy), 32'h0);
      end

      // loop-back and silence vectors: {mode, req, sample_end, audio_input, exp out, exp busy}
      tv[0] = '{2'b11, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0};
      tv[1] = '{2'b11, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0};
      tv[2] = '{2'b11, 1'b1, 1'b1, 16'h5678, 16'h1234, 1'b0};
      tv[3] = '{2'b11, 1'b1, 1'b0, 16'h0000, 16'h5678, 1'b0};
      tv[4] = '{2'b00, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
      tv[5] = '{2'b11, 1'b0, 1'b1, 16'h8001, 16'h0000, 1'b0};
      tv[6] = '{2'b11, 1'b1, 1'b0, 16'h0000, 16'h8001, 1'b0};
      tv[7] = '{2'b11, 1'b0, 1'b0, 16'h7FFF, 16'h8001, 1'b0};
      tv[8] = '{2'b11, 1'b1, 1'b0, 16'h7FFF, 16'h8001, 1'b0};
      tv[9] = '{2'b10, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
      for (int i = 0; i < 10; i++) begin
         mode = tv[i].mode; sample_req = tv[i].req; sample_end = tv[i].send; audio_input = tv[i].ain;
         @(posedge clk); #1;
         sample_req = 1'b0; sample_end = 1'b0;
         check($sformatf("vec%0d out", i), 32'(audio_output), 32'(tv[i].out));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy));
      end
      m_last = 16'h8001;

      // square attack to full scale, then alternating +/- full-scale samples
      run_reqs(2'b10, 1'b1, 16'h8000, 8'd255, 70, "sq_att");
      do_req(2'b10, 1'b1, 16'h8000, 8'd255, "sq_a", a);
      do_req(2'b10, 1'b1, 16'h8000, 8'd255, "sq_b", b);
      check("sq alternate", 32'((a == 16'h7F7F && b == 16'h8080) || (a == 16'h8080 && b == 16'h7F7F)), 32'h1);
      check("sq busy", 32'(busy), 32'h1);

      run_reqs(2'b10, 1'b0, 16'h8000, 8'd255, 64, "sq_rel");
      check("rel busy", 32'(busy), 32'h0);

      // sine sweep through the 127 -> 0 index wrap, volume tracking, release/re-attack
      run_reqs(2'b01, 1'b1, 16'h0200, 8'd255, 204, "sine");
      run_reqs(2'b01, 1'b1, 16'h0200, 8'd100, 5, "vol_dn");
      run_reqs(2'b01, 1'b0, 16'h0200, 8'd100, 3, "rel_part");
      run_reqs(2'b01, 1'b1, 16'h0200, 8'd100, 3, "reatt");
      run_reqs(2'b10, 1'b0, 16'h0100, 8'd100, 40, "to_idle");
      run_reqs(2'b10, 1'b1, 16'h3000, 8'd255, 5, "att_hi");
      run_reqs(2'b10, 1'b1, 16'h3000, 8'd10, 3, "vol_cut");
      run_reqs(2'b01, 1'b1, 16'hFFF0, 8'd255, 6, "ph_wrap");
      run_reqs(2'b11, 1'b1, 16'h0400, 8'd255, 2, "fb_env");
      run_reqs(2'b00, 1'b0, 16'h0400, 8'd255, 70, "silent_rel");

      // asynchronous reset part-way through an attack
      run_reqs(2'b10, 1'b1, 16'h1000, 8'd200, 10, "att2");
      check("pre-rst busy", 32'(busy), 32'h1);
      #3 reset_n = 1'b0;
      #1;
      check("async rst out", 32'(audio_output), 32'h0);
      check("async rst busy", 32'(busy), 32'h0);
      m_env = 0; m_phase = 0; m_state = S_IDLE; m_last = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_reqs(2'b11, 1'b0, 16'h1000, 8'd200, 1, "last_rst");
      run_reqs(2'b10, 1'b1, 16'h1000, 8'd200, 20, "restart");

      check("sb empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
